// File: rtl/video_rx_monitor.sv
// Receive-side video timing monitor: recovers active-pixel coordinates from HS/VS/BLANK,
// measures each frame against HDISP x VDISP, declares lock and streams locked pixels.
module video_rx_monitor #(
  parameter int HDISP       = 800,
  parameter int VDISP       = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int CNT_W       = 12
) (
  input  logic             pixel_clk,
  input  logic             pixel_rst_n,
  input  logic             vid_hs,
  input  logic             vid_vs,
  input  logic             vid_blank,
  input  logic [23:0]      vid_rgb,
  output logic             locked,
  output logic             pix_valid,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic [23:0]      pix_rgb,
  output logic             pix_sof,
  output logic             pix_eol,
  output logic             frame_done,
  output logic [31:0]      frame_sum,
  output logic [CNT_W-1:0] meas_hdisp,
  output logic [CNT_W-1:0] meas_vdisp,
  output logic [15:0]      frame_count,
  output logic             err_pulse,
  output logic [7:0]       err_count,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] HDISP_C = CNT_W'(HDISP);
  localparam logic [CNT_W-1:0] VDISP_C = CNT_W'(VDISP);
  localparam logic [CNT_W-1:0] EOL_X   = CNT_W'(HDISP - 1);
  localparam int               GOOD_W  = $clog2(LOCK_FRAMES + 1);
  localparam logic [GOOD_W-1:0] LOCK_C = GOOD_W'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic                count_frame, flag_err;

  logic                s1_hs, s1_vs, s1_blank;
  logic [23:0]         s1_rgb;
  logic                s2_hs, s2_vs, s2_blank;

  logic [CNT_W-1:0]    x_cnt, y_cnt, last_len, first_len;
  logic                have_first, line_bad;
  logic [31:0]         acc;

  logic                line_close, frame_close, hs_in_active;
  logic [CNT_W-1:0]    y_line, len_line;
  logic                bad_line, frame_ok;
  logic [31:0]         pix_term;

  // Stage 1 holds the sampled inputs; stage 2 is only kept for edge detection.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_blank <= 1'b0;
      s1_rgb   <= '0;
      s2_hs    <= 1'b0;
      s2_vs    <= 1'b0;
      s2_blank <= 1'b0;
    end else begin
      s1_hs    <= vid_hs;
      s1_vs    <= vid_vs;
      s1_blank <= vid_blank;
      s1_rgb   <= vid_rgb;
      s2_hs    <= s1_hs;
      s2_vs    <= s1_vs;
      s2_blank <= s1_blank;
    end
  end

  // Line close is folded in first so a coincident vsync edge sees the final line.
  always_comb begin
    line_close   = s2_blank & ~s1_blank;
    frame_close  = s2_vs & ~s1_vs;
    hs_in_active = s2_hs & ~s1_hs & s1_blank;
    pix_term     = s1_blank ? {8'h00, s1_rgb} : 32'h0;
    y_line       = y_cnt;
    len_line     = last_len;
    if (line_close) begin
      y_line   = (y_cnt == CNT_MAX) ? y_cnt : y_cnt + 1'b1;
      len_line = x_cnt;
    end
    bad_line = line_bad | hs_in_active |
               (line_close & have_first & (x_cnt != first_len));
    frame_ok = (len_line == HDISP_C) && (y_line == VDISP_C) && !bad_line && !s1_blank;
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      last_len   <= '0;
      first_len  <= '0;
      have_first <= 1'b0;
      line_bad   <= 1'b0;
      acc        <= '0;
    end else begin
      if (line_close) begin
        x_cnt <= '0;
      end else if (s1_blank && (x_cnt != CNT_MAX)) begin
        x_cnt <= x_cnt + 1'b1;
      end
      if (frame_close) begin
        y_cnt      <= '0;
        last_len   <= '0;
        have_first <= 1'b0;
        line_bad   <= 1'b0;
        acc        <= pix_term;
      end else begin
        y_cnt    <= y_line;
        last_len <= len_line;
        line_bad <= bad_line;
        acc      <= acc + pix_term;
        if (line_close && !have_first) begin
          first_len  <= x_cnt;
          have_first <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    count_frame = 1'b0;
    flag_err    = 1'b0;
    if (frame_close) begin
      case (state_q)
        ST_SEARCH: begin
          state_d = ST_MEASURE;
          good_d  = '0;
        end
        ST_MEASURE: begin
          if (frame_ok) begin
            good_d = good_q + 1'b1;
            if (good_d == LOCK_C) state_d = ST_LOCKED;
          end else begin
            good_d = '0;
          end
        end
        ST_LOCKED: begin
          if (frame_ok) begin
            count_frame = 1'b1;
          end else begin
            flag_err = 1'b1;
            good_d   = '0;
            state_d  = ST_MEASURE;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  // pix_valid qualifies pix_* for exactly one cycle per active pixel; there is no backpressure.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state_q     <= ST_SEARCH;
      good_q      <= '0;
      frame_done  <= 1'b0;
      frame_sum   <= '0;
      meas_hdisp  <= '0;
      meas_vdisp  <= '0;
      frame_count <= '0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      pix_sof     <= 1'b0;
      pix_eol     <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      frame_done <= 1'b0;
      err_pulse  <= 1'b0;
      if (frame_close && (state_q != ST_SEARCH)) begin
        frame_done <= 1'b1;
        frame_sum  <= acc;
        meas_hdisp <= len_line;
        meas_vdisp <= y_line;
      end
      if (count_frame) frame_count <= frame_count + 16'd1;
      if (flag_err) begin
        err_pulse <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
      pix_valid <= (state_q == ST_LOCKED) && s1_blank;
      pix_sof   <= (state_q == ST_LOCKED) && s1_blank && (x_cnt == '0) && (y_cnt == '0);
      pix_eol   <= (state_q == ST_LOCKED) && s1_blank && (x_cnt == EOL_X);
      if (s1_blank) begin
        pix_x   <= x_cnt;
        pix_y   <= y_cnt;
        pix_rgb <= s1_rgb;
      end
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_video_rx_monitor.sv
// Scoreboard bench for video_rx_monitor on a reduced 16x6 raster: drivers push expected
// pixels and frame results, a forked monitor pops and compares them as the DUT emits.
module tb_video_rx_monitor;

  localparam int HDISP = 16, VDISP = 6, LOCK_FRAMES = 2, CNT_W = 12;
  localparam int HFP = 2, HSW = 3, HBP = 4;
  localparam int VFP = 1, VSW = 2, VBP = 1;
  localparam int GLITCH_X = 5, RST_X = 5;
  localparam int PW = 2*CNT_W + 24 + 2;
  localparam int FW = 32 + 2*CNT_W + 1;

  logic             pixel_clk, pixel_rst_n;
  logic             vid_hs, vid_vs, vid_blank;
  logic [23:0]      vid_rgb;
  logic             locked, pix_valid, pix_sof, pix_eol, frame_done, err_pulse;
  logic [CNT_W-1:0] pix_x, pix_y, meas_hdisp, meas_vdisp;
  logic [23:0]      pix_rgb;
  logic [31:0]      frame_sum;
  logic [15:0]      frame_count;
  logic [7:0]       err_count;
  logic [1:0]       dbg_state;

  int checks, errors, err_seen;
  bit pix_ignore;
  logic [PW-1:0] exp_q[$];
  logic [FW-1:0] frm_q[$];

  video_rx_monitor #(
    .HDISP(HDISP), .VDISP(VDISP), .LOCK_FRAMES(LOCK_FRAMES), .CNT_W(CNT_W)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_blank(vid_blank), .vid_rgb(vid_rgb),
    .locked(locked), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_rgb(pix_rgb), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .frame_done(frame_done), .frame_sum(frame_sum),
    .meas_hdisp(meas_hdisp), .meas_vdisp(meas_vdisp),
    .frame_count(frame_count), .err_pulse(err_pulse), .err_count(err_count),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_locked", locked, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_x", pix_x, 0);
    check("rst_pix_y", pix_y, 0);
    check("rst_pix_rgb", pix_rgb, 0);
    check("rst_pix_sof", pix_sof, 0);
    check("rst_pix_eol", pix_eol, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_sum", frame_sum, 0);
    check("rst_meas_hdisp", meas_hdisp, 0);
    check("rst_meas_vdisp", meas_vdisp, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_count", err_count, 0);
  endtask

  // scoreboard monitor
  task automatic monitor_loop();
    logic [PW-1:0] e;
    logic [FW-1:0] f;
    forever begin
      @(negedge pixel_clk);
      if (!pix_valid) begin
        checks++;
        if (pix_sof || pix_eol) begin
          errors++;
          $display("FAIL flag_without_valid act=%0b%0b exp=00", pix_sof, pix_eol);
        end
      end else if (!pix_ignore) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pix_unexpected act=x%0d,y%0d exp=no_pixel", pix_x, pix_y);
        end else begin
          e = exp_q.pop_front();
          if ({pix_x, pix_y, pix_rgb, pix_sof, pix_eol} !== e) begin
            errors++;
            $display("FAIL pix act=%h exp=%h", {pix_x, pix_y, pix_rgb, pix_sof, pix_eol}, e);
          end
        end
      end
      if (frame_done) begin
        checks++;
        if (frm_q.size() == 0) begin
          errors++;
          $display("FAIL frame_done_unexpected act=v%0d exp=none", meas_vdisp);
        end else begin
          f = frm_q.pop_front();
          if (meas_hdisp !== f[24:13] || meas_vdisp !== f[12:1] ||
              (f[0] && frame_sum !== f[56:25])) begin
            errors++;
            $display("FAIL frame act=h%0d v%0d s%0h exp=h%0d v%0d s%0h chk%0b",
                     meas_hdisp, meas_vdisp, frame_sum, f[24:13], f[12:1], f[56:25], f[0]);
          end
        end
      end
      if (err_pulse) err_seen++;
    end
  endtask

  // drivers
  task automatic cyc(input logic hs, input logic vs, input logic blank, input logic [23:0] rgb);
    @(negedge pixel_clk);
    vid_hs = hs; vid_vs = vs; vid_blank = blank; vid_rgb = rgb;
  endtask

  task automatic blank_line(input logic vs);
    for (int i = 0; i < HDISP + HFP; i++) cyc(1'b1, vs, 1'b0, 24'h0);
    for (int i = 0; i < HSW; i++)         cyc(1'b0, vs, 1'b0, 24'h0);
    for (int i = 0; i < HBP; i++)         cyc(1'b1, vs, 1'b0, 24'h0);
  endtask

  task automatic lead_in();
    blank_line(1'b1);
    for (int i = 0; i < VSW; i++) blank_line(1'b0);
    for (int i = 0; i < VBP; i++) blank_line(1'b1);
  endtask

  task automatic drive_frame(input int nlines, input int short_line, input int glitch_line,
                             input int rst_line, input bit exp_pix, input bit exp_done,
                             input logic [23:0] seed);
    logic [31:0] sum;
    logic [23:0] rgb;
    int len, rst_left, g_left, v_close;
    bit push, chk;
    sum = 0; push = exp_pix; chk = 1'b1; rst_left = 0; g_left = 0; v_close = nlines;
    for (int y = 0; y < nlines; y++) begin
      len = (y == short_line) ? HDISP - 1 : HDISP;
      for (int x = 0; x < len; x++) begin
        rgb = 24'(x + y) ^ seed;
        if (y == glitch_line && x == GLITCH_X) begin
          g_left  = 2;
          chk     = 1'b0;
          v_close = nlines - y;
          if (exp_done) frm_q.push_back({32'h0, CNT_W'(HDISP), CNT_W'(y), 1'b0});
        end
        if (push)
          exp_q.push_back({CNT_W'(x), CNT_W'(y), rgb, (x == 0 && y == 0), (x == HDISP - 1)});
        if (g_left > 0) push = 1'b0;
        if (y == rst_line && x == RST_X) rst_left = 3;
        cyc(1'b1, (g_left == 0), 1'b1, rgb);
        if (g_left > 0) g_left--;
        sum += {8'h00, rgb};
        if (rst_left > 0) begin
          pixel_rst_n = 1'b0;
          #1 check_reset_outputs();
          rst_left--;
        end else begin
          pixel_rst_n = 1'b1;
        end
      end
      for (int i = 0; i < HFP + (HDISP - len); i++) cyc(1'b1, 1'b1, 1'b0, 24'h0);
      for (int i = 0; i < HSW; i++) cyc(1'b0, 1'b1, 1'b0, 24'h0);
      for (int i = 0; i < HBP; i++) cyc(1'b1, 1'b1, 1'b0, 24'h0);
    end
    for (int i = 0; i < VFP; i++) blank_line(1'b1);
    if (exp_done) frm_q.push_back({sum, CNT_W'(HDISP), CNT_W'(v_close), chk});
    for (int i = 0; i < VSW; i++) blank_line(1'b0);
    for (int i = 0; i < VBP; i++) blank_line(1'b1);
  endtask

  initial begin
    checks = 0; errors = 0; err_seen = 0; pix_ignore = 1'b0;
    vid_hs = 1'b1; vid_vs = 1'b1; vid_blank = 1'b0; vid_rgb = 24'h0;
    pixel_rst_n = 1'b0;
    fork
      monitor_loop();
    join_none
    repeat (3) @(negedge pixel_clk);
    check_reset_outputs();
    check("rst_state", dbg_state, 0);
    @(negedge pixel_clk);
    pixel_rst_n = 1'b1;

    // three nominal frames: lock after the second close, count from the third
    lead_in();
    check("t1_state_measure", dbg_state, 1);
    drive_frame(VDISP, -1, -1, -1, 1'b0, 1'b1, 24'h000000);
    check("t1_locked_a", locked, 0);
    drive_frame(VDISP, -1, -1, -1, 1'b0, 1'b1, 24'h000000);
    check("t1_locked_b", locked, 1);
    check("t1_fc_b", frame_count, 0);
    drive_frame(VDISP, -1, -1, -1, 1'b1, 1'b1, 24'h000000);
    check("t1_fc_c", frame_count, 1);
    check("t1_hdisp", meas_hdisp, 16);
    check("t1_vdisp", meas_vdisp, 6);

    // locked stream, rgb = x+y: sum over 16x6 is 960
    drive_frame(VDISP, -1, -1, -1, 1'b1, 1'b1, 24'h000000);
    check("t2_sum", frame_sum, 960);
    check("t2_fc", frame_count, 2);

    // one short line while locked
    drive_frame(VDISP, 2, -1, -1, 1'b1, 1'b1, 24'h123456);
    check("t3_err_seen", err_seen, 1);
    check("t3_err_count", err_count, 1);
    check("t3_locked", locked, 0);
    check("t3_fc_hold", frame_count, 2);
    drive_frame(VDISP, -1, -1, -1, 1'b0, 1'b1, 24'h00ff00);
    check("t3_locked_f", locked, 0);
    drive_frame(VDISP, -1, -1, -1, 1'b0, 1'b1, 24'hff0000);
    check("t3_relock", locked, 1);
    drive_frame(VDISP, -1, -1, -1, 1'b1, 1'b1, 24'h0000ff);
    check("t3_fc", frame_count, 3);

    // one extra line while locked
    drive_frame(VDISP + 1, -1, -1, -1, 1'b1, 1'b1, 24'h800001);
    check("t4_vdisp", meas_vdisp, 7);
    check("t4_err_count", err_count, 2);
    check("t4_locked", locked, 0);
    drive_frame(VDISP, -1, -1, -1, 1'b0, 1'b1, 24'h000000);
    check("t4_locked_j", locked, 0);
    drive_frame(VDISP, -1, -1, -1, 1'b0, 1'b1, 24'h000000);
    check("t4_relock", locked, 1);

    // reset mid-line 3; the broken frame's vsync only leaves SEARCH
    pix_ignore = 1'b1;
    drive_frame(VDISP, -1, -1, 3, 1'b0, 1'b0, 24'h0a0b0c);
    pix_ignore = 1'b0;
    check("t5_state_measure", dbg_state, 1);
    check("t5_locked", locked, 0);
    check("t5_fc", frame_count, 0);
    check("t5_err_count", err_count, 0);
    drive_frame(VDISP, -1, -1, -1, 1'b0, 1'b1, 24'h000000);
    check("t5_locked_m", locked, 0);
    drive_frame(VDISP, -1, -1, -1, 1'b0, 1'b1, 24'h000000);
    check("t5_relock", locked, 1);
    drive_frame(VDISP, -1, -1, -1, 1'b1, 1'b1, 24'h5a5a5a);
    check("t5_fc", frame_count, 1);

    // vsync falls inside active video on line 3
    drive_frame(VDISP, -1, 3, -1, 1'b1, 1'b1, 24'h000000);
    check("t6_err_seen", err_seen, 3);
    check("t6_err_count", err_count, 1);
    check("t6_locked", locked, 0);
    check("t6_vdisp_remnant", meas_vdisp, 3);
    drive_frame(VDISP, -1, -1, -1, 1'b0, 1'b1, 24'h000000);
    drive_frame(VDISP, -1, -1, -1, 1'b0, 1'b1, 24'h000000);
    check("t6_relock", locked, 1);
    drive_frame(VDISP, -1, -1, -1, 1'b1, 1'b1, 24'hc3c3c3);
    check("t6_fc", frame_count, 2);

    repeat (10) @(negedge pixel_clk);
    check("end_pix_queue", exp_q.size(), 0);
    check("end_frame_queue", frm_q.size(), 0);
    check("end_err_seen", err_seen, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
